// File: rtl/hw_accel_stream_bridge.sv
// DMA <-> accelerator stream bridge: unpacks DMA read words into pixels, packs pixels into DMA write words.
// Defining HW_ACCEL_BRIDGE_STATS_EN adds the saturating stall/drop statistics ports.
module hw_accel_stream_bridge #(
   parameter int DATA_WIDTH          = 32,
   parameter int PIX_WIDTH           = 8,
   parameter int FRAME_PIXELS        = 307200,
   parameter int DMA_TRANSFER_LENGTH = 1920
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    mode,
   output logic                    busy,
   output logic                    frame_done,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [DATA_WIDTH-1:0]   s_data,
   input  logic [DATA_WIDTH/8-1:0] s_keep,
   output logic [PIX_WIDTH-1:0]    px_out,
   output logic                    px_out_valid,
   input  logic                    px_out_ready,
   input  logic [PIX_WIDTH-1:0]    px_in,
   input  logic                    px_in_valid,
   output logic                    px_in_ready,
   output logic [DATA_WIDTH-1:0]   m_data,
   output logic                    m_valid,
   input  logic                    m_ready,
`ifdef HW_ACCEL_BRIDGE_STATS_EN
   output logic                    m_last,
   output logic [31:0]             stat_in_stall,
   output logic [31:0]             stat_out_stall,
   output logic [15:0]             stat_drop
`else
   output logic                    m_last
`endif
);

   localparam int PPW       = DATA_WIDTH / PIX_WIDTH;
   localparam int CW        = $clog2(FRAME_PIXELS + 1);
   localparam int WW        = (DMA_TRANSFER_LENGTH > 1) ? $clog2(DMA_TRANSFER_LENGTH) : 1;
   localparam int HW        = $clog2(PPW + 1);
   localparam int REP_LANES = (PPW < 3) ? PPW : 3;

   localparam logic [CW-1:0] FRAME_N       = CW'(FRAME_PIXELS);
   localparam logic [CW-1:0] FRAME_LAST_PX = CW'(FRAME_PIXELS - 1);
   localparam logic [WW-1:0] BURST_LAST    = WW'(DMA_TRANSFER_LENGTH - 1);
   localparam logic [HW-1:0] PPW_N         = HW'(PPW);
   localparam logic [HW-1:0] PPW_LAST      = HW'(PPW - 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

   state_e                state_q, state_d;
   logic                  mode_q, mode_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
   logic [CW-1:0]         in_cnt_q, in_cnt_d;
   logic [PIX_WIDTH-1:0]  px_out_q, px_out_d;
   logic                  px_out_valid_q, px_out_valid_d;
   logic [DATA_WIDTH-1:0] pack_q, pack_d;
   logic [HW-1:0]         pack_cnt_q, pack_cnt_d;
   logic [CW-1:0]         out_cnt_q, out_cnt_d;
   logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
   logic                  m_valid_q, m_valid_d;
   logic                  m_last_q, m_last_d;
   logic [WW-1:0]         word_cnt_q, word_cnt_d;

   logic                  s_ready_c, px_in_ready_c, px_take, px_acc;
   logic                  frame_end_px, burst_end, emit;
   logic [DATA_WIDTH-1:0] lane_word, rep_word;

   // Holding register only accepts a new word once every pixel of the previous one has left.
   assign s_ready_c     = (state_q == RUN) && (hold_cnt_q == '0) && (in_cnt_q != FRAME_N);
   assign px_take       = (state_q == RUN) && (hold_cnt_q != '0) && (in_cnt_q != FRAME_N) &&
                          (!px_out_valid_q || px_out_ready);
   assign px_in_ready_c = ((state_q == RUN) || (state_q == FLUSH)) && (out_cnt_q != FRAME_N) &&
                          (!m_valid_q || m_ready);
   assign px_acc        = px_in_valid && px_in_ready_c;
   assign frame_end_px  = (out_cnt_q == FRAME_LAST_PX);
   assign burst_end     = (word_cnt_q == BURST_LAST);
   assign emit          = px_acc && (!mode_q || (pack_cnt_q == PPW_LAST) || frame_end_px);

   always_comb begin
      rep_word = '0;
      for (int i = 0; i < REP_LANES; i++) rep_word[i*PIX_WIDTH +: PIX_WIDTH] = px_in;
      lane_word = pack_q | (DATA_WIDTH'(px_in) << (pack_cnt_q * PIX_WIDTH));
   end

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d = state_q;
      mode_d  = mode_q;
      unique case (state_q)
         IDLE:  if (start) begin
                   state_d = RUN;
                   mode_d  = mode;
                end
         RUN:   if (in_cnt_q == FRAME_N) state_d = FLUSH;
         FLUSH: if ((out_cnt_q == FRAME_N) && (pack_cnt_q == '0) && !m_valid_q) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      hold_d         = hold_q;
      hold_cnt_d     = hold_cnt_q;
      in_cnt_d       = in_cnt_q;
      px_out_d       = px_out_q;
      px_out_valid_d = px_out_valid_q;
      pack_d         = pack_q;
      pack_cnt_d     = pack_cnt_q;
      out_cnt_d      = out_cnt_q;
      m_data_d       = m_data_q;
      m_valid_d      = m_valid_q;
      m_last_d       = m_last_q;
      word_cnt_d     = word_cnt_q;

      // Leaving RUN discards any pixels of the final word beyond the frame.
      if (state_q != RUN) begin
         hold_cnt_d = '0;
      end else if (px_take) begin
         hold_d     = hold_q >> PIX_WIDTH;
         hold_cnt_d = hold_cnt_q - HW'(1);
      end else if (s_valid && s_ready_c && (&s_keep)) begin
         hold_d     = s_data;
         hold_cnt_d = mode_q ? PPW_N : HW'(1);
      end

      if (px_take) begin
         px_out_d       = hold_q[PIX_WIDTH-1:0];
         px_out_valid_d = 1'b1;
         in_cnt_d       = in_cnt_q + CW'(1);
      end else if (px_out_ready) begin
         px_out_valid_d = 1'b0;
      end

      if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
         m_last_d  = 1'b0;
      end

      if (px_acc) begin
         out_cnt_d = out_cnt_q + CW'(1);
         if (emit) begin
            m_data_d   = mode_q ? lane_word : rep_word;
            m_valid_d  = 1'b1;
            m_last_d   = burst_end || frame_end_px;
            word_cnt_d = (burst_end || frame_end_px) ? '0 : word_cnt_q + WW'(1);
            pack_d     = '0;
            pack_cnt_d = '0;
         end else begin
            pack_d     = lane_word;
            pack_cnt_d = pack_cnt_q + HW'(1);
         end
      end

      if (state_q == DONE) begin
         in_cnt_d       = '0;
         out_cnt_d      = '0;
         word_cnt_d     = '0;
         px_out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q        <= IDLE;
         mode_q         <= 1'b0;
         hold_q         <= '0;
         hold_cnt_q     <= '0;
         in_cnt_q       <= '0;
         px_out_q       <= '0;
         px_out_valid_q <= 1'b0;
         pack_q         <= '0;
         pack_cnt_q     <= '0;
         out_cnt_q      <= '0;
         m_data_q       <= '0;
         m_valid_q      <= 1'b0;
         m_last_q       <= 1'b0;
         word_cnt_q     <= '0;
      end else begin
         state_q        <= state_d;
         mode_q         <= mode_d;
         hold_q         <= hold_d;
         hold_cnt_q     <= hold_cnt_d;
         in_cnt_q       <= in_cnt_d;
         px_out_q       <= px_out_d;
         px_out_valid_q <= px_out_valid_d;
         pack_q         <= pack_d;
         pack_cnt_q     <= pack_cnt_d;
         out_cnt_q      <= out_cnt_d;
         m_data_q       <= m_data_d;
         m_valid_q      <= m_valid_d;
         m_last_q       <= m_last_d;
         word_cnt_q     <= word_cnt_d;
      end
   end

   assign busy         = (state_q != IDLE);
   assign frame_done   = (state_q == DONE);
   assign s_ready      = s_ready_c;
   assign px_out       = px_out_q;
   assign px_out_valid = px_out_valid_q;
   assign px_in_ready  = px_in_ready_c;
   assign m_data       = m_data_q;
   assign m_valid      = m_valid_q;
   assign m_last       = m_last_q;

`ifdef HW_ACCEL_BRIDGE_STATS_EN
   logic [31:0] stat_in_stall_q, stat_out_stall_q;
   logic [15:0] stat_drop_q;
   logic        clr_stats;

   assign clr_stats = (state_q == IDLE) && start;

   // Counters saturate rather than wrap so a long stall never reads back as a short one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_in_stall_q  <= '0;
         stat_out_stall_q <= '0;
         stat_drop_q      <= '0;
      end else if (clr_stats) begin
         stat_in_stall_q  <= '0;
         stat_out_stall_q <= '0;
         stat_drop_q      <= '0;
      end else begin
         if ((state_q == RUN) && s_valid && !s_ready_c && (stat_in_stall_q != '1))
            stat_in_stall_q <= stat_in_stall_q + 32'd1;
         if (m_valid_q && !m_ready && (stat_out_stall_q != '1))
            stat_out_stall_q <= stat_out_stall_q + 32'd1;
         if (s_valid && s_ready_c && !(&s_keep) && (stat_drop_q != '1))
            stat_drop_q <= stat_drop_q + 16'd1;
      end
   end

   assign stat_in_stall  = stat_in_stall_q;
   assign stat_out_stall = stat_out_stall_q;
   assign stat_drop      = stat_drop_q;
`endif

endmodule

// File: tb/tb_hw_accel_stream_bridge.sv
// Self-checking bench for hw_accel_stream_bridge: two instances (16-pixel and 10-pixel frames),
// accelerator modelled as a loopback, table of frame scenarios plus reset / stall sequences.
module tb_hw_accel_stream_bridge;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start_a, start_b, mode, s_valid, m_ready, pxgo, sel, mon_en, stall_en;
   logic [31:0] s_data;
   logic [3:0]  s_keep;

   logic        busy_a, fd_a, s_ready_a, pov_a, pir_a, m_valid_a, m_last_a;
   logic [7:0]  px_a;
   logic [31:0] m_data_a;
   logic        busy_b, fd_b, s_ready_b, pov_b, pir_b, m_valid_b, m_last_b;
   logic [7:0]  px_b;
   logic [31:0] m_data_b;
`ifdef HW_ACCEL_BRIDGE_STATS_EN
   logic [31:0] sis_a, sos_a, sis_b, sos_b;
   logic [15:0] sd_a, sd_b;
`endif

   hw_accel_stream_bridge #(.DATA_WIDTH(32), .PIX_WIDTH(8), .FRAME_PIXELS(16), .DMA_TRANSFER_LENGTH(4)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .mode(mode), .busy(busy_a), .frame_done(fd_a),
      .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data), .s_keep(s_keep),
      .px_out(px_a), .px_out_valid(pov_a), .px_out_ready(pir_a & pxgo),
      .px_in(px_a), .px_in_valid(pov_a & pxgo), .px_in_ready(pir_a),
      .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready),
`ifdef HW_ACCEL_BRIDGE_STATS_EN
      .m_last(m_last_a), .stat_in_stall(sis_a), .stat_out_stall(sos_a), .stat_drop(sd_a)
`else
      .m_last(m_last_a)
`endif
   );

   hw_accel_stream_bridge #(.DATA_WIDTH(32), .PIX_WIDTH(8), .FRAME_PIXELS(10), .DMA_TRANSFER_LENGTH(4)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .mode(mode), .busy(busy_b), .frame_done(fd_b),
      .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data), .s_keep(s_keep),
      .px_out(px_b), .px_out_valid(pov_b), .px_out_ready(pir_b & pxgo),
      .px_in(px_b), .px_in_valid(pov_b & pxgo), .px_in_ready(pir_b),
      .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready),
`ifdef HW_ACCEL_BRIDGE_STATS_EN
      .m_last(m_last_b), .stat_in_stall(sis_b), .stat_out_stall(sos_b), .stat_drop(sd_b)
`else
      .m_last(m_last_b)
`endif
   );

   // View of whichever instance the current scenario drives.
   logic        busy_x, fd_x, s_ready_x, pov_x, pfire_x, m_valid_x, m_last_x;
   logic [7:0]  px_x;
   logic [31:0] m_data_x;
   assign busy_x    = sel ? busy_b    : busy_a;
   assign fd_x      = sel ? fd_b      : fd_a;
   assign s_ready_x = sel ? s_ready_b : s_ready_a;
   assign pov_x     = sel ? pov_b     : pov_a;
   assign pfire_x   = sel ? (pov_b & pir_b & pxgo) : (pov_a & pir_a & pxgo);
   assign px_x      = sel ? px_b      : px_a;
   assign m_valid_x = sel ? m_valid_b : m_valid_a;
   assign m_last_x  = sel ? m_last_b  : m_last_a;
   assign m_data_x  = sel ? m_data_b  : m_data_a;

   typedef struct packed {logic [31:0] data; logic last;} mword_t;
   typedef struct {
      logic sel; logic mode; logic fixed; int nwords; int drop;
      logic stall; logic poke; int exp_words; int exp_lasts;
   } vec_t;

   logic [7:0]  exp_px[$];
   mword_t      exp_m[$];
   logic [31:0] words[32];
   logic [3:0]  keeps[32];
   int checks = 0, failures = 0;
   int mwords, lasts, dones;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pixel order and write-word packing derived from the words driven.
   task automatic build_expect(input logic md, input int fp, input int nw);
      logic [7:0]  pix[$];
      logic [31:0] w;
      mword_t      e;
      int          total;
      for (int i = 0; i < nw; i++)
         if (keeps[i] == 4'hF)
            for (int l = 0; l < (md ? 4 : 1); l++)
               if (pix.size() < fp) pix.push_back(words[i][8*l +: 8]);
      foreach (pix[i]) exp_px.push_back(pix[i]);
      total = md ? (pix.size() + 3) / 4 : pix.size();
      for (int k = 0; k < total; k++) begin
         w = '0;
         if (md) begin
            for (int l = 0; l < 4; l++)
               if (4*k + l < pix.size()) w[8*l +: 8] = pix[4*k + l];
         end else begin
            w = {8'h00, pix[k], pix[k], pix[k]};
         end
         e.data = w;
         e.last = ((k % 4) == 3) || (k == total - 1);
         exp_m.push_back(e);
      end
   endtask

   // Offer words in order; a word counts as taken when s_ready is high ahead of the edge.
   task automatic feed(input int n, input logic poke, input logic md, output int got);
      int cyc = 0;
      got = 0;
      while (got < n && cyc < 2000) begin
         s_valid = 1'b1;
         s_data  = words[got];
         s_keep  = keeps[got];
         if (poke) begin
            start_a = (cyc == 3);
            mode    = (cyc == 3) ? ~md : md;
         end
         @(negedge clk);
         if (s_ready_x) got++;
         @(posedge clk); #1;
         cyc++;
      end
      s_valid = 1'b0;
      start_a = 1'b0;
      mode    = md;
   endtask

   task automatic pulse_start(input logic which, input logic md);
      @(posedge clk); #1;
      mode = md;
      if (which) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic run_vector(input vec_t v);
      int fp, got, cyc;
      fp = v.sel ? 10 : 16;
      for (int w = 0; w < v.nwords; w++) begin
         words[w] = v.fixed ? 32'h04030201 : $urandom;
         keeps[w] = (w == v.drop) ? 4'b0111 : 4'hF;
      end
      build_expect(v.mode, fp, v.nwords);
      mwords = 0; lasts = 0; dones = 0;
      sel = v.sel; stall_en = v.stall; mon_en = 1'b1;
      pulse_start(v.sel, v.mode);
      check("busy_after_start", 32'(busy_x), 32'd1);
      feed(v.nwords, v.poke, v.mode, got);
      check("words_consumed", got, v.nwords);
      cyc = 0;
      while (dones == 0 && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("frame_done_seen", 32'(dones != 0), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("frame_done_pulses", dones, 32'd1);
      check("m_word_count", mwords, v.exp_words);
      check("m_last_count", lasts, v.exp_lasts);
      check("px_queue_drained", exp_px.size(), 32'd0);
      check("m_queue_drained", exp_m.size(), 32'd0);
      check("busy_idle", 32'(busy_x), 32'd0);
`ifdef HW_ACCEL_BRIDGE_STATS_EN
      check("stat_drop", 32'(v.sel ? sd_b : sd_a), (v.drop >= 0) ? 32'd1 : 32'd0);
`endif
      stall_en = 1'b0;
      mon_en   = 1'b0;
      exp_px.delete();
      exp_m.delete();
   endtask

   // Output monitor / scoreboard consumer, sampling on the falling edge.
   initial begin
      logic [31:0] hold_md;
      logic [7:0]  hold_px;
      logic        hold_ml, m_stalled, px_stalled;
      mword_t      e;
      m_stalled = 1'b0;
      px_stalled = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (m_stalled) begin
               check("m_valid_held", 32'(m_valid_x), 32'd1);
               check("m_data_stable", m_data_x, hold_md);
               check("m_last_stable", 32'(m_last_x), 32'(hold_ml));
            end
            if (px_stalled) begin
               check("px_valid_held", 32'(pov_x), 32'd1);
               check("px_out_stable", 32'(px_x), 32'(hold_px));
            end
            if (pfire_x) begin
               check("px_queue_nonempty", 32'(exp_px.size() != 0), 32'd1);
               if (exp_px.size() != 0) check("px_out", 32'(px_x), 32'(exp_px.pop_front()));
            end
            if (m_valid_x && m_ready) begin
               mwords++;
               if (m_last_x) lasts++;
               check("m_queue_nonempty", 32'(exp_m.size() != 0), 32'd1);
               if (exp_m.size() != 0) begin
                  e = exp_m.pop_front();
                  check("m_data", m_data_x, e.data);
                  check("m_last", 32'(m_last_x), 32'(e.last));
               end
            end
            if (fd_x) dones++;
            m_stalled  = m_valid_x && !m_ready;
            px_stalled = pov_x && !pfire_x;
            hold_md = m_data_x;
            hold_ml = m_last_x;
            hold_px = px_x;
         end else begin
            m_stalled  = 1'b0;
            px_stalled = 1'b0;
         end
      end
   end

   // Downstream back-pressure: DMA write ready and accelerator ready/valid gating.
   initial begin
      m_ready = 1'b1;
      pxgo    = 1'b1;
      forever begin
         @(posedge clk); #1;
         m_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
         pxgo    = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      vec_t v_after_rst;
      int   got;
      vecs[0] = '{sel:1'b0, mode:1'b0, fixed:1'b0, nwords:16, drop:-1, stall:1'b0, poke:1'b0, exp_words:16, exp_lasts:4};
      vecs[1] = '{sel:1'b0, mode:1'b1, fixed:1'b1, nwords:4,  drop:-1, stall:1'b0, poke:1'b0, exp_words:4,  exp_lasts:1};
      vecs[2] = '{sel:1'b1, mode:1'b1, fixed:1'b0, nwords:3,  drop:-1, stall:1'b0, poke:1'b0, exp_words:3,  exp_lasts:1};
      vecs[3] = '{sel:1'b0, mode:1'b0, fixed:1'b0, nwords:16, drop:-1, stall:1'b1, poke:1'b0, exp_words:16, exp_lasts:4};
      vecs[4] = '{sel:1'b0, mode:1'b1, fixed:1'b0, nwords:4,  drop:-1, stall:1'b1, poke:1'b0, exp_words:4,  exp_lasts:1};
      vecs[5] = '{sel:1'b0, mode:1'b1, fixed:1'b1, nwords:5,  drop:2,  stall:1'b0, poke:1'b0, exp_words:4,  exp_lasts:1};
      vecs[6] = '{sel:1'b0, mode:1'b0, fixed:1'b0, nwords:17, drop:2,  stall:1'b1, poke:1'b1, exp_words:16, exp_lasts:4};
      v_after_rst = '{sel:1'b0, mode:1'b1, fixed:1'b0, nwords:4, drop:-1, stall:1'b0, poke:1'b0, exp_words:4, exp_lasts:1};

      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mode = 1'b0; s_valid = 1'b0;
      s_data = '0; s_keep = '0; sel = 1'b0; mon_en = 1'b0; stall_en = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_frame_done", 32'(fd_a), 32'd0);
      check("rst_s_ready", 32'(s_ready_a), 32'd0);
      check("rst_px_out_valid", 32'(pov_a), 32'd0);
      check("rst_px_in_ready", 32'(pir_a), 32'd0);
      check("rst_m_valid", 32'(m_valid_a), 32'd0);
      check("rst_m_last", 32'(m_last_a), 32'd0);
      check("rst_m_data", m_data_a, 32'd0);
      check("rst_px_out", 32'(px_a), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle_s_ready", 32'(s_ready_a), 32'd0);

      for (int i = 0; i < 7; i++) run_vector(vecs[i]);

      // Abort a frame after 7 pixels, then a clean frame must come out from pixel 0.
      sel = 1'b0;
      for (int w = 0; w < 7; w++) begin
         words[w] = $urandom;
         keeps[w] = 4'hF;
      end
      pulse_start(1'b0, 1'b0);
      feed(7, 1'b0, 1'b0, got);
      check("abort_words_consumed", got, 32'd7);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_busy", 32'(busy_a), 32'd0);
      check("midrst_m_valid", 32'(m_valid_a), 32'd0);
      check("midrst_px_out_valid", 32'(pov_a), 32'd0);
      check("midrst_s_ready", 32'(s_ready_a), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_vector(v_after_rst);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
